assign_2: RTL and testbench

Serial pattern-detecting lock. It samples a one-bit serial input `d` on every rising clock edge and asserts `unlock` for one cycle after the most recent bits equal the programmed unlock pattern. The default pattern is 0,1,1,1,0. It is a Moore-style recogniser that sits between a debounced key/serial input and the lock actuator control.

---
 rtl/assign_2.sv | 108 ++++++++++
 tb/tb_assign_2.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/assign_2.sv
// ----------------------------------------------------------------------------
// assign_2 : serial pattern-detecting lock
//
// Watches a one-bit serial stream and pulses 'unlock' for one cycle each time
// the most recently received bits equal PATTERN (MSB is received first).
// Overlapping occurrences are detected using the KMP failure rule, so the
// tail of one match can start the next one.
//
// Parameters
//   PATTERN_LEN : pattern length in bits (2..16)
//   PATTERN     : unlock code, MSB = first bit received, LSB = last bit
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   reset  : asynchronous active-low reset (0 = clear immediately)
//   d      : serial data, one bit sampled per rising edge
//   unlock : registered Moore output, high while the state is S_PATTERN_LEN
// ----------------------------------------------------------------------------
module assign_2 #(
    parameter int                     PATTERN_LEN = 5,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 5'b01110
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic unlock
);

    // State register width: enough to hold match counts 0..PATTERN_LEN.
    localparam int SW = $clog2(PATTERN_LEN + 1);

    // One SW-bit entry per (state, input bit) pair.
    localparam int TW = 2 * (PATTERN_LEN + 1) * SW;

    localparam logic [SW-1:0] S_IDLE = '0;
    localparam logic [SW-1:0] S_FULL = SW'(PATTERN_LEN);

    // Builds the complete transition table at elaboration time. For every
    // state k and input bit b the next state is the longest j such that the
    // first j pattern bits equal the last j bits of (first k pattern bits, b).
    // Trying j up to k+1 covers the simple "advance" case as well as the
    // failure-rule fallback, so one search handles both.
    function automatic logic [TW-1:0] build_table();
        logic [TW-1:0] tbl;
        int            best;
        int            pos;
        logic          ok;
        logic          sbit;
        tbl = '0;
        for (int k = 0; k <= PATTERN_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                for (int j = 1; j <= PATTERN_LEN; j++) begin
                    if (j <= k + 1) begin
                        ok = 1'b1;
                        for (int i = 0; i < j; i++) begin
                            pos = k + 1 - j + i;
                            if (pos < k)
                                sbit = PATTERN[PATTERN_LEN-1-pos];
                            else
                                sbit = (b != 0);
                            if (PATTERN[PATTERN_LEN-1-i] != sbit)
                                ok = 1'b0;
                        end
                        if (ok)
                            best = j;
                    end
                end
                tbl[(k*2+b)*SW +: SW] = SW'(best);
            end
        end
        return tbl;
    endfunction

    localparam logic [TW-1:0] NEXT_TABLE = build_table();

    // The state is the match counter itself: S_k holds the value k.
    logic [SW-1:0] state;
    logic [SW-1:0] state_next;

    // Table lookup for the next state. Encodings above PATTERN_LEN are never
    // reached in normal operation and are steered back to S0.
    always_comb begin
        state_next = S_IDLE;
        for (int k = 0; k <= PATTERN_LEN; k++) begin
            if (state == SW'(k)) begin
                if (d)
                    state_next = NEXT_TABLE[(k*2+1)*SW +: SW];
                else
                    state_next = NEXT_TABLE[(k*2)*SW +: SW];
            end
        end
    end

    // State and output register. 'unlock' is registered from the next-state
    // value so it always equals (state == S_FULL) and never sees 'd'
    // combinationally; both clear together on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_IDLE;
            unlock <= 1'b0;
        end else begin
            state  <= state_next;
            unlock <= (state_next == S_FULL);
        end
    end

endmodule

// File: tb/tb_assign_2.sv
// ----------------------------------------------------------------------------
// tb_assign_2 : directed testbench for assign_2
//
// Two instances share clock, reset and data: one with the default 5-bit
// pattern 01110, one with PATTERN_LEN=3 / PATTERN=111. Expected values are
// hand-computed from the pattern definitions.
// ----------------------------------------------------------------------------
module tb_assign_2;

    logic clk;
    logic reset;
    logic d;
    logic unlock5;
    logic unlock3;

    int num_checks;
    int num_fails;

    assign_2 u_dut5 (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .unlock (unlock5)
    );

    assign_2 #(
        .PATTERN_LEN (3),
        .PATTERN     (3'b111)
    ) u_dut3 (
        .clk    (clk),
        .reset  (reset),
        .d      (d),
        .unlock (unlock3)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic  rst_n;
        logic  din;
        logic  exp;
        string tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic r, input logic dv,
                                    input logic e, input string t);
        vec_t v;
        v.rst_n = r;
        v.din   = dv;
        v.exp   = e;
        v.tag   = t;
        vecs.push_back(v);
    endfunction

    // Drive inputs on a falling edge and wait for the next falling edge,
    // so exactly one rising edge samples them before the check.
    task automatic applyStimulus(input logic r, input logic dv);
        reset = r;
        d     = dv;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic act,
                               input logic exp);
        num_checks++;
        if (act !== exp) begin
            num_fails++;
            $display("[TB] FAIL %s: unlock=%b expected %b", tag, act, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        d     = 1'b0;
        num_checks = 0;
        num_fails  = 0;

        // Default pattern: match, then a 1 moves to S2 and unlock drops.
        add_vec(1'b0, 1'b0, 1'b0, "reset_state");
        add_vec(1'b1, 1'b0, 1'b0, "basic_b1");
        add_vec(1'b1, 1'b1, 1'b0, "basic_b2");
        add_vec(1'b1, 1'b1, 1'b0, "basic_b3");
        add_vec(1'b1, 1'b1, 1'b0, "basic_b4");
        add_vec(1'b1, 1'b0, 1'b1, "basic_b5_unlock");
        add_vec(1'b1, 1'b1, 1'b0, "basic_b6_drop");
        // Overlap: second pulse after only 4 new bits.
        add_vec(1'b0, 1'b0, 1'b0, "ovl_reset");
        add_vec(1'b1, 1'b0, 1'b0, "ovl_b1");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b2");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b3");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b4");
        add_vec(1'b1, 1'b0, 1'b1, "ovl_b5_unlock");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b6");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b7");
        add_vec(1'b1, 1'b1, 1'b0, "ovl_b8");
        add_vec(1'b1, 1'b0, 1'b1, "ovl_b9_unlock");
        // Near miss: extra 1 sends state back to S0.
        add_vec(1'b0, 1'b0, 1'b0, "near_reset");
        add_vec(1'b1, 1'b0, 1'b0, "near_b1");
        add_vec(1'b1, 1'b1, 1'b0, "near_b2");
        add_vec(1'b1, 1'b1, 1'b0, "near_b3");
        add_vec(1'b1, 1'b1, 1'b0, "near_b4");
        add_vec(1'b1, 1'b1, 1'b0, "near_b5");
        add_vec(1'b1, 1'b0, 1'b0, "near_b6_nopulse");
        add_vec(1'b1, 1'b1, 1'b0, "near_b7");
        add_vec(1'b1, 1'b1, 1'b0, "near_b8");
        add_vec(1'b1, 1'b1, 1'b0, "near_b9");
        add_vec(1'b1, 1'b0, 1'b1, "near_b10_unlock");
        // Repeated zeros stay in S1, then the pattern still completes.
        add_vec(1'b1, 1'b0, 1'b0, "zeros_b1");
        add_vec(1'b1, 1'b0, 1'b0, "zeros_b2");
        add_vec(1'b1, 1'b1, 1'b0, "zeros_b3");
        add_vec(1'b1, 1'b1, 1'b0, "zeros_b4");
        add_vec(1'b1, 1'b1, 1'b0, "zeros_b5");
        add_vec(1'b1, 1'b0, 1'b1, "zeros_b6_unlock");

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].din);
            checkOutput(vecs[i].tag, unlock5, vecs[i].exp);
        end

        // Async reset mid-sequence: reach S4, drop reset between edges.
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("async_pre", unlock5, 1'b0);
        #2 reset = 1'b0;
        #1 checkOutput("async_low", unlock5, 1'b0);
        @(negedge clk);
        // A lone 0 after release must not complete the old partial match.
        applyStimulus(1'b1, 1'b0);
        checkOutput("async_after_0", unlock5, 1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("async_after_0111", unlock5, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("async_full_unlock", unlock5, 1'b1);

        // Reset while unlock is high: must fall before any clock edge.
        #2 reset = 1'b0;
        #1 checkOutput("reset_in_unlock", unlock5, 1'b0);
        @(negedge clk);

        // Short all-ones pattern chains S3 -> S3.
        applyStimulus(1'b0, 1'b1);
        checkOutput("len3_reset", unlock3, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b1", unlock3, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b2", unlock3, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b3_unlock", unlock3, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b4_unlock", unlock3, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b5_unlock", unlock3, 1'b1);
        applyStimulus(1'b1, 1'b0);
        checkOutput("len3_b6_zero", unlock3, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("len3_b7", unlock3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", num_checks, num_fails);
        $finish;
    end

endmodule
